prefetch_unit: RTL
==================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2 to 16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rstd  input  1  asynchronous active-low reset.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch address; word-aligned.
REQ-007 imem_ready  input  1  request accepted when imem_req and imem_ready are both high.
REQ-008 imem_rvalid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance.
REQ-009 imem_rdata  input  32  response instruction word.
REQ-010 ins_valid  output  1  instruction available to the execute stage.
REQ-011 ins  output  32  instruction word.
REQ-012 ins_pc  output  32  address of ins.
REQ-013 ins_ready  input  1  execute stage consumes; handshake is ins_valid and ins_ready.
REQ-014 redirect  input  1  branch or jump taken; flushes the unit.
REQ-015 redirect_pc  input  32  new fetch address; bits [1:0] ignored.

Function
REQ-016 fetch_pc SHALL drive imem_addr and advance by 4 on each accepted request, wrapping modulo 2^32.
REQ-017 imem_req SHALL be high only when (outstanding + queue count) < DEPTH and redirect is low.
  - outstanding = accepted requests whose responses are not yet received.
  - Consequence: the queue never overflows.
REQ-018 A non-dropped response SHALL push {resp_pc, imem_rdata}; resp_pc then advances by 4.
REQ-019 Queue SHALL be a circular buffer with wrapping read/write pointers.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pop on empty is impossible, because ins_valid = !empty.
REQ-020 ins and ins_pc SHALL present the queue head; they are held stable while ins_valid is high and ins_ready is low.
REQ-021 Latency without bypass: request accepted in cycle N, response in N+1 -> ins_valid in N+2.
REQ-022 In a redirect cycle the unit SHALL:
  - clear the queue;
  - set fetch_pc and resp_pc to {redirect_pc[31:2], 2'b00};
  - load drop_cnt with all outstanding requests, including any response arriving in that same cycle;
  - clear outstanding.
REQ-023 While drop_cnt > 0, each imem_rvalid SHALL be discarded and drop_cnt decremented.
  - New requests may issue during this period, limited by REQ-017 counting drop_cnt as outstanding.
REQ-024 A handshake occurring in the redirect cycle SHALL count as consumed; the flush still applies.
REQ-025 A redirect arriving while drop_cnt > 0 SHALL add the new outstanding count to drop_cnt.
REQ-026 imem_rvalid with outstanding = 0 and drop_cnt = 0 SHALL be ignored.

Reset
REQ-027 rstd low SHALL asynchronously set:
  - fetch_pc = resp_pc = RESET_PC;
  - queue empty, outstanding = 0, drop_cnt = 0;
  - imem_req = 0, ins_valid = 0, ins = 0, ins_pc = 0.
REQ-028 Reset asserted mid-operation SHALL abandon all in-flight requests; the first request after release SHALL be to RESET_PC.
REQ-029 imem_req SHALL first assert in the first clock edge after rstd deasserts.

Configuration
REQ-030 Macro PREFETCH_BYPASS_EN, when defined, SHALL enable bypass when the queue is empty and a non-dropped response arrives:
  - ins_valid asserts in the same cycle, with ins = imem_rdata and ins_pc = resp_pc.
  - If ins_ready is high, the entry is not written to the queue.
  - Latency becomes N+1.
REQ-031 Without PREFETCH_BYPASS_EN, outputs SHALL come only from registered queue state; latency is as in REQ-021.

Verification
REQ-032 Reset, imem always ready with 1-cycle response, ins_ready = 1 -> addresses 0, 4, 8, ...; ins_valid first high in cycle 3 (cycle 2 with bypass); ins_pc sequence 0, 4, 8.
REQ-033 ins_ready = 0 with DEPTH = 4 -> exactly 4 requests issue, then imem_req = 0; one ins_ready pulse -> exactly one new request.
REQ-034 Two requests outstanding, redirect with redirect_pc = 0x100 -> next imem_addr = 0x100; both stale responses dropped; first ins_pc = 0x100.
REQ-035 Response and redirect in the same cycle -> response dropped; queue empty in the next cycle.
REQ-036 rstd pulsed low mid-stream with 3 entries queued -> ins_valid = 0 immediately; after release the first imem_addr = RESET_PC.
REQ-037 fetch_pc = 0xFFFF_FFFC, accepted request -> next imem_addr = 0x0000_0000.

Source files
------------

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: in-order fetch into a DEPTH-entry circular queue with redirect flush.
// Optional same-cycle response bypass to the execute stage: define PREFETCH_BYPASS_EN.
module prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstd,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        ins_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

  logic [31:0]   fetch_pc, resp_pc;
  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic          started;

  logic [CW+1:0] in_use;
  logic          empty, accept, resp_live, resp_drop, resp_good;
  logic          push, pop, bypass_take;
  logic [31:0]   target_pc;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign target_pc      = {redirect_pc[31:2], 2'b00};

  // Dropped responses still occupy an imem slot, so they count toward the limit.
  assign in_use    = (CW+2)'(count) + (CW+2)'(outstanding) + (CW+2)'(drop_cnt);
  assign imem_req  = started && !redirect && (in_use < DEPTH_W);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;

  assign empty     = (count == '0);
  assign resp_live = imem_rvalid && ((drop_cnt != '0) || (outstanding != '0));
  assign resp_drop = imem_rvalid && (drop_cnt != '0);
  assign resp_good = imem_rvalid && (drop_cnt == '0) && (outstanding != '0) && !redirect;

  always_comb begin
    bypass_take = 1'b0;
    ins_valid   = !empty;
    ins         = '0;
    ins_pc      = '0;
    if (!empty) begin
      ins    = mem_data[rd_ptr];
      ins_pc = mem_pc[rd_ptr];
    end
`ifdef PREFETCH_BYPASS_EN
    if (empty && resp_good) begin
      ins_valid   = 1'b1;
      ins         = imem_rdata;
      ins_pc      = resp_pc;
      bypass_take = ins_ready;
    end
`endif
  end

  assign pop  = !empty && ins_ready;
  assign push = resp_good && !bypass_take;

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      started <= 1'b1;
      if (redirect) begin
        fetch_pc    <= target_pc;
        resp_pc     <= target_pc;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        count       <= '0;
        outstanding <= '0;
        // A response landing in this cycle retires one in-flight request on its way out.
        drop_cnt    <= drop_cnt + outstanding - CW'(resp_live);
      end else begin
        if (accept)    fetch_pc <= fetch_pc + 32'd4;
        if (resp_good) resp_pc  <= resp_pc + 32'd4;
        outstanding <= outstanding + CW'(accept) - CW'(resp_good);
        drop_cnt    <= drop_cnt - CW'(resp_drop);
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= resp_pc;
    end
  end

endmodule
